stream_flush_sequencer: RTL and testbench

//  Master side of the flush interface of a chain of flushable spill registers.
//  - Sits between a producer and the chain, and forwards data while idle.
//  - On request, blocks the producer and drives flush_o for FlushCycles cycles.
//  - Guarantees flush_o and out_valid_o are never high together, then returns a one-cycle ack.

---
 rtl/stream_flush_seq_pkg.sv | 18 +
 rtl/stream_occ_tracker.sv | 45 ++++
 rtl/stream_flush_sequencer.sv | 101 ++++++++++
 tb/tb_stream_flush_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_flush_seq_pkg.sv
// Shared types and helpers for the stream flush sequencer.
// State encoding and flush-counter width calculation.
package stream_flush_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        ACK
    } state_e;

    // Counter must hold 0..flush_cycles-1 and never be zero bits wide.
    function automatic int cnt_w(input int flush_cycles);
        int w;
        w = $clog2(flush_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_occ_tracker.sv
// Saturating occupancy and dropped-beat counters for a flushable chain.
// Only instantiated when STREAM_FLUSH_SEQUENCER_OCC_EN is defined.
module stream_occ_tracker #(
    parameter int OccWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                flush_start_i,
    output logic [OccWidth-1:0] occupancy_o,
    output logic [OccWidth-1:0] dropped_o
);

    localparam logic [OccWidth-1:0] OccMax = '1;

    logic [OccWidth-1:0] occupancy;
    logic [OccWidth-1:0] dropped;
    logic [OccWidth:0]   drop_sum;
    logic [OccWidth-1:0] dropped_sat;

    always_comb begin
        drop_sum    = {1'b0, dropped} + {1'b0, occupancy};
        dropped_sat = drop_sum[OccWidth] ? OccMax : drop_sum[OccWidth-1:0];
    end

    // A flush discards everything in flight, so it overrides any same-cycle beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occupancy <= '0;
            dropped   <= '0;
        end else if (flush_start_i) begin
            occupancy <= '0;
            dropped   <= dropped_sat;
        end else if (inc_i && !dec_i && (occupancy != OccMax)) begin
            occupancy <= occupancy + OccWidth'(1);
        end else if (dec_i && !inc_i && (occupancy != '0)) begin
            occupancy <= occupancy - OccWidth'(1);
        end
    end

    assign occupancy_o = occupancy;
    assign dropped_o   = dropped;

endmodule

// File: rtl/stream_flush_sequencer.sv
// Flush master for a chain of flushable spill registers: passes data while idle,
// gates the producer and pulses flush_o/flush_ack_o on request. Option: STREAM_FLUSH_SEQUENCER_OCC_EN.
module stream_flush_sequencer
    import stream_flush_seq_pkg::*;
#(
    parameter type T           = logic,
    parameter int  FlushCycles = 1,
    parameter int  OccWidth    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_req_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [$bits(T)-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [$bits(T)-1:0] out_data_o,
`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
    input  logic                mon_valid_i,
    input  logic                mon_ready_i,
    output logic [OccWidth-1:0] occupancy_o,
    output logic [OccWidth-1:0] dropped_o,
`endif
    output logic                flush_o
);

    localparam int             CntW    = cnt_w(FlushCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(FlushCycles - 1);

    state_e          state;
    state_e          state_next;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The request cycle itself is already gated so a beat can never slip in
    // one cycle before flush_o rises.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        out_valid_o = 1'b0;
        in_ready_o  = 1'b0;
        flush_o     = 1'b0;
        flush_ack_o = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req_i) begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                end else begin
                    out_valid_o = in_valid_i;
                    in_ready_o  = out_ready_i;
                end
            end
            FLUSH: begin
                flush_o  = 1'b1;
                cnt_next = cnt + CntW'(1);
                if (cnt == CntLast) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                flush_ack_o = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o     = (state != IDLE);
    assign out_data_o = in_data_i;

`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
    stream_occ_tracker #(
        .OccWidth(OccWidth)
    ) u_occ (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (out_valid_o && out_ready_i),
        .dec_i        (mon_valid_i && mon_ready_i),
        .flush_start_i((state == FLUSH) && (cnt == '0)),
        .occupancy_o  (occupancy_o),
        .dropped_o    (dropped_o)
    );
`endif

endmodule

// File: tb/tb_stream_flush_sequencer.sv
// Directed self-checking bench for stream_flush_sequencer (FlushCycles=3, 8-bit payload).
// Occupancy scenario is compiled in only with STREAM_FLUSH_SEQUENCER_OCC_EN.
module tb_stream_flush_sequencer;

    localparam int FC = 3;
    localparam int OW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       flushReq;
    logic       flushAck;
    logic       busy;
    logic       inValid;
    logic       inReady;
    logic [7:0] inData;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic       flushOut;
`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
    logic          monValid;
    logic          monReady;
    logic [OW-1:0] occupancy;
    logic [OW-1:0] dropped;
`endif

    int checks = 0;
    int errors = 0;
    logic ackPrev = 1'b0;

    always #5 clk = ~clk;

    stream_flush_sequencer #(
        .T          (logic [7:0]),
        .FlushCycles(FC),
        .OccWidth   (OW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_req_i(flushReq),
        .flush_ack_o(flushAck),
        .busy_o     (busy),
        .in_valid_i (inValid),
        .in_ready_o (inReady),
        .in_data_i  (inData),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_data_o (outData),
`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
        .mon_valid_i(monValid),
        .mon_ready_i(monReady),
        .occupancy_o(occupancy),
        .dropped_o  (dropped),
`endif
        .flush_o    (flushOut)
    );

    // Invariants watched on every cycle of every scenario.
    always @(negedge clk) begin
        checks++;
        if (flushOut === 1'b1 && outValid === 1'b1) begin
            errors++;
            $display("[TB] FAIL overlap t=%0t flush_o=%b out_valid_o=%b required not both 1", $time, flushOut, outValid);
        end
        if (flushAck === 1'b1 && ackPrev === 1'b1) begin
            errors++;
            $display("[TB] FAIL ack_width t=%0t flush_ack_o high two cycles in a row", $time);
        end
        ackPrev = flushAck;
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic mv, input logic mr, input logic rq);
        inValid  = v;
        outReady = r;
        flushReq = rq;
`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
        monValid = mv;
        monReady = mr;
`else
        if (mv || mr) $display("[TB] monitor stimulus ignored in this build");
`endif
        nextCycle();
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        flushReq = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        inData   = 8'h00;
`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
        monValid = 1'b0;
        monReady = 1'b0;
`endif
        nextCycle();
        nextCycle();
        @(negedge clk);
        checks++;
        if ({flushOut, flushAck, busy, outValid, inReady} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got flush/ack/busy/ov/ir=%b required 00000",
                     {flushOut, flushAck, busy, outValid, inReady});
        end
`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
        checks++;
        if (occupancy !== '0 || dropped !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters got occ=%0d drop=%0d required 0 0", occupancy, dropped);
        end
`endif
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_pass_through;
        int idx = 0;
        int cyc = 0;
        inValid = 1'b1;
        while (idx < 10 && cyc < 200) begin
            outReady = 1'($urandom_range(0, 1));
            inData   = 8'(idx);
            @(negedge clk);
            checks++;
            if ({inReady, outValid, flushOut, busy} !== {outReady, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL pt_ctrl cyc=%0d ir/ov/fl/busy=%b required %b", cyc,
                         {inReady, outValid, flushOut, busy}, {outReady, 3'b100});
            end
            if (outValid && outReady) begin
                checks++;
                if (outData !== 8'(idx)) begin
                    errors++;
                    $display("[TB] FAIL pt_data beat=%0d got %h required %h", idx, outData, 8'(idx));
                end
                idx++;
            end
            nextCycle();
            cyc++;
        end
        inValid = 1'b0;
        checks++;
        if (idx != 10) begin
            errors++;
            $display("[TB] FAIL pt_timeout beats=%0d required 10", idx);
        end
    endtask

    task automatic test_flush_timing;
        logic expReady, expFlush, expAck, expBusy;
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 15; c++) begin
            flushReq = (c >= 5) && (c <= 6 + FC);
            @(negedge clk);
            expReady = !((c >= 5) && (c <= 6 + FC));
            expFlush = (c >= 6) && (c <= 5 + FC);
            expAck   = (c == 6 + FC);
            expBusy  = (c >= 6) && (c <= 6 + FC);
            checks++;
            if ({inReady, flushOut, flushAck, busy} !== {expReady, expFlush, expAck, expBusy}) begin
                errors++;
                $display("[TB] FAIL flush_timing c=%0d ir/fl/ack/busy=%b required %b", c,
                         {inReady, flushOut, flushAck, busy}, {expReady, expFlush, expAck, expBusy});
            end
            nextCycle();
        end
        flushReq = 1'b0;
    endtask

    task automatic test_data_hold;
        logic reqOn = 1'b1;
        int accepts = 0;
        int acceptCycle = -1;
        inValid  = 1'b1;
        inData   = 8'hA5;
        outReady = 1'b1;
        for (int c = 0; c < 14; c++) begin
            flushReq = reqOn;
            @(negedge clk);
            checks++;
            if (outData !== 8'hA5) begin
                errors++;
                $display("[TB] FAIL hold_data c=%0d got %h required a5", c, outData);
            end
            if (flushAck) reqOn = 1'b0;
            if (inValid && inReady) begin
                accepts++;
                acceptCycle = c;
            end
            nextCycle();
            if (acceptCycle >= 0) inValid = 1'b0;
        end
        flushReq = 1'b0;
        checks++;
        if (accepts != 1 || acceptCycle != FC + 2) begin
            errors++;
            $display("[TB] FAIL hold_accept count=%0d cycle=%0d required 1 at %0d", accepts, acceptCycle, FC + 2);
        end
    endtask

    task automatic test_back_to_back;
        int acks = 0;
        int ackAt[2] = '{-1, -1};
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 12; c++) begin
            flushReq = (c == 0) || (c == 2);
            @(negedge clk);
            if (flushAck) begin
                if (acks < 2) ackAt[acks] = c;
                acks++;
            end
            nextCycle();
        end
        checks++;
        if (acks != 1 || ackAt[0] != FC + 1) begin
            errors++;
            $display("[TB] FAIL repulse_ack count=%0d first=%0d required 1 at %0d", acks, ackAt[0], FC + 1);
        end
        acks = 0;
        ackAt = '{-1, -1};
        for (int c = 0; c < 16; c++) begin
            flushReq = (c <= FC + 2);
            @(negedge clk);
            if (c == FC + 2) begin
                checks++;
                if ({inReady, flushOut, busy} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL b2b_reqcycle ir/fl/busy=%b required 000", {inReady, flushOut, busy});
                end
            end
            if (flushAck) begin
                if (acks < 2) ackAt[acks] = c;
                acks++;
            end
            nextCycle();
        end
        flushReq = 1'b0;
        checks++;
        if (acks != 2 || ackAt[0] != FC + 1 || ackAt[1] != 2 * FC + 3) begin
            errors++;
            $display("[TB] FAIL b2b_acks count=%0d at %0d,%0d required 2 at %0d,%0d",
                     acks, ackAt[0], ackAt[1], FC + 1, 2 * FC + 3);
        end
    endtask

    task automatic test_reset_mid_flush;
        int acks = 0;
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 9; c++) begin
            flushReq = (c == 0);
            rst      = (c == 2);
            @(negedge clk);
            if (flushAck) acks++;
            if (c == 2) begin
                checks++;
                if (flushOut !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rst_pre flush_o=%b required 1", flushOut);
                end
            end
            if (c >= 3) begin
                checks++;
                if ({flushOut, busy, inReady} !== 3'b001) begin
                    errors++;
                    $display("[TB] FAIL rst_mid c=%0d fl/busy/ir=%b required 001", c, {flushOut, busy, inReady});
                end
            end
            nextCycle();
        end
        rst = 1'b0;
        checks++;
        if (acks != 0) begin
            errors++;
            $display("[TB] FAIL rst_noack acks=%0d required 0", acks);
        end
    endtask

`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
    task automatic test_occupancy;
        test_reset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (occupancy !== 8'd3) begin
            errors++;
            $display("[TB] FAIL occ_fill got %0d required 3", occupancy);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (occupancy !== 8'd3) begin
            errors++;
            $display("[TB] FAIL occ_both got %0d required 3", occupancy);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < FC + 2; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (occupancy !== 8'd0 || dropped !== 8'd3) begin
            errors++;
            $display("[TB] FAIL occ_flush1 occ=%0d drop=%0d required 0 3", occupancy, dropped);
        end
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < FC + 2; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (occupancy !== 8'd0 || dropped !== 8'd5) begin
            errors++;
            $display("[TB] FAIL occ_flush2 occ=%0d drop=%0d required 0 5", occupancy, dropped);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (occupancy !== 8'd0) begin
            errors++;
            $display("[TB] FAIL occ_floor got %0d required 0", occupancy);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_flush_timing();
        test_data_hold();
        test_back_to_back();
        test_reset_mid_flush();
`ifdef STREAM_FLUSH_SEQUENCER_OCC_EN
        test_occupancy();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
